branch_predictor_table: RTL
===========================

BRANCH_PREDICTOR_TABLE -- requirements
Module: branch_predictor_table

Interface
REQ-001 SHALL have parameter CTR_BITS, default 2, saturating-counter width, legal range 2..4.
REQ-002 SHALL have parameter INDEX_BITS, default 4, table index width; ENTRIES = 2**INDEX_BITS.
REQ-003 SHALL have parameter GSHARE, default 0; 0 selects bimodal indexing, 1 selects gshare indexing (index XOR GHR).
REQ-004 SHALL have parameter MISS_CNT_BITS, default 8, miss-statistics counter width.
REQ-005 SHALL have port CLOCK  input  1  single clock; all state changes on the rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port INIT  input  1  synchronous soft flush, active-high.
REQ-008 SHALL have port LOOKUP_INDEX  input  INDEX_BITS  fetch-side branch index (PC bits).
REQ-009 SHALL have port PREDICTION  output  1  taken prediction for LOOKUP_INDEX.
REQ-010 SHALL have port LOOKUP_HIST  output  INDEX_BITS  GHR value used for this lookup; zero when GSHARE=0.
REQ-011 SHALL have port UPDATE_VALID  input  1  resolved branch present this cycle.
REQ-012 SHALL have port UPDATE_INDEX  input  INDEX_BITS  PC index of the resolved branch.
REQ-013 SHALL have port UPDATE_HIST  input  INDEX_BITS  LOOKUP_HIST captured when the branch was predicted.
REQ-014 SHALL have port OUTCOME  input  1  actual direction, 1 = taken.
REQ-015 SHALL have port MISS  input  1  resolved branch was mispredicted.
REQ-016 SHALL have port MISS_COUNT  output  MISS_CNT_BITS  saturating count of mispredictions.

Function
REQ-017 SHALL hold ENTRIES counters, each CTR_BITS wide; the prediction is the counter MSB.
REQ-018 SHALL form the read index as LOOKUP_INDEX when GSHARE=0, and as LOOKUP_INDEX XOR GHR when GSHARE=1.
REQ-019 SHALL form the write index as UPDATE_INDEX when GSHARE=0, and as UPDATE_INDEX XOR UPDATE_HIST when GSHARE=1.
REQ-020 SHALL drive PREDICTION combinationally from the current table state, with zero-cycle lookup latency.
REQ-021 SHALL, on an edge with UPDATE_VALID=1, increment the indexed counter if OUTCOME=1 and decrement it if OUTCOME=0.
REQ-022 SHALL saturate counters at 2**CTR_BITS-1 and at 0, with no wrap-around.
REQ-023 SHALL, when GSHARE=1, shift OUTCOME into the GHR LSB on every UPDATE_VALID edge.
REQ-024 SHALL, when GSHARE=1 and MISS=1, instead load the GHR with {UPDATE_HIST[INDEX_BITS-2:0], OUTCOME}, repairing speculative history.
REQ-025 SHALL increment MISS_COUNT on an edge with UPDATE_VALID=1 and MISS=1, holding at all-ones.
REQ-026 SHALL ignore OUTCOME, MISS and UPDATE_* when UPDATE_VALID=0, making no state change.
REQ-027 SHALL resolve a same-cycle lookup and update to the same entry read-before-write: PREDICTION shows the pre-update value, and the new value is visible after the edge.
REQ-028 SHALL update only the indexed entry; all other entries are unchanged.
REQ-029 SHALL give INIT priority over UPDATE_VALID in the same cycle: apply the flush and discard the update.

Reset
REQ-030 SHALL, while RESET=0 and independent of CLOCK, set every counter to weakly-not-taken (2**(CTR_BITS-1)-1), GHR to 0 and MISS_COUNT to 0.
REQ-031 SHALL, during reset, hold PREDICTION=0 and LOOKUP_HIST=0.
REQ-032 SHALL, on an edge with INIT=1, apply the same values as REQ-030, synchronously.
REQ-033 SHALL, when RESET is asserted mid-update, clear all state immediately and lose the pending update.

Verification
REQ-034 SHALL cover: defaults, after reset, two taken updates to index 3 -> counter goes 1->2->3; PREDICTION at index 3 changes 0->1 after the first edge; index 4 still reads 0.
REQ-035 SHALL cover: defaults, five taken then five not-taken updates to index 7 -> counter saturates at 3, then at 0; PREDICTION ends at 0.
REQ-036 SHALL cover: LOOKUP_INDEX = UPDATE_INDEX = 2, counter 1, taken update -> PREDICTION=0 in that cycle and 1 after the edge.
REQ-037 SHALL cover: MISS_CNT_BITS=2, four updates with MISS=1 -> MISS_COUNT goes 1, 2, 3, 3; with UPDATE_VALID=0 and MISS=1 -> no change.
REQ-038 SHALL cover: GSHARE=1, updates with taken, taken, not-taken -> GHR=4'b0110; then MISS=1, UPDATE_HIST=4'b0001, OUTCOME=1 -> GHR=4'b0011.
REQ-039 SHALL cover: INIT=1 and UPDATE_VALID=1 together, then RESET pulsed low between edges -> all counters 1, MISS_COUNT 0, GHR 0, immediately on RESET.

Source files
------------

// File: rtl/branch_predictor_table.sv
// Direction predictor: a table of saturating counters, indexed bimodally or via gshare,
// plus a global history register and a saturating misprediction counter.
module branch_predictor_table #(
  parameter int CTR_BITS      = 2,
  parameter int INDEX_BITS    = 4,
  parameter int GSHARE        = 0,
  parameter int MISS_CNT_BITS = 8
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     INIT,
  input  logic [INDEX_BITS-1:0]    LOOKUP_INDEX,
  output logic                     PREDICTION,
  output logic [INDEX_BITS-1:0]    LOOKUP_HIST,
  input  logic                     UPDATE_VALID,
  input  logic [INDEX_BITS-1:0]    UPDATE_INDEX,
  input  logic [INDEX_BITS-1:0]    UPDATE_HIST,
  input  logic                     OUTCOME,
  input  logic                     MISS,
  output logic [MISS_CNT_BITS-1:0] MISS_COUNT
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

  logic [CTR_BITS-1:0]      tbl_q [ENTRIES];
  logic [INDEX_BITS-1:0]    ghr_q, ghr_d;
  logic [MISS_CNT_BITS-1:0] miss_cnt_q, miss_cnt_d;
  logic [INDEX_BITS-1:0]    rd_idx, wr_idx;
  logic [CTR_BITS-1:0]      ctr_d;

  function automatic logic [CTR_BITS-1:0] ctr_step(input logic [CTR_BITS-1:0] ctr,
                                                   input logic taken);
    if (taken) return (ctr == CTR_MAX) ? ctr : ctr + CTR_BITS'(1);
    else       return (ctr == '0)      ? ctr : ctr - CTR_BITS'(1);
  endfunction

  function automatic logic [MISS_CNT_BITS-1:0] miss_sat_inc(input logic [MISS_CNT_BITS-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + MISS_CNT_BITS'(1);
  endfunction

  always_comb begin
    rd_idx     = (GSHARE != 0) ? (LOOKUP_INDEX ^ ghr_q) : LOOKUP_INDEX;
    wr_idx     = (GSHARE != 0) ? (UPDATE_INDEX ^ UPDATE_HIST) : UPDATE_INDEX;
    ctr_d      = ctr_step(tbl_q[wr_idx], OUTCOME);
    ghr_d      = ghr_q;
    miss_cnt_d = miss_cnt_q;
    if (UPDATE_VALID) begin
      // A mispredict rebuilds history from the snapshot taken at prediction time.
      if (GSHARE != 0)
        ghr_d = MISS ? {UPDATE_HIST[INDEX_BITS-2:0], OUTCOME}
                     : {ghr_q[INDEX_BITS-2:0], OUTCOME};
      if (MISS)
        miss_cnt_d = miss_sat_inc(miss_cnt_q);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CTR_WEAK_NT;
      ghr_q      <= '0;
      miss_cnt_q <= '0;
    end else if (INIT) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CTR_WEAK_NT;
      ghr_q      <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (UPDATE_VALID) tbl_q[wr_idx] <= ctr_d;
      ghr_q      <= ghr_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Read-before-write: the lookup sees the table as it stands before this edge.
  assign PREDICTION  = tbl_q[rd_idx][CTR_BITS-1];
  assign LOOKUP_HIST = ghr_q;
  assign MISS_COUNT  = miss_cnt_q;

endmodule
